// File: rtl/intercal_alu_host.sv
// intercal_alu_host
// Host-side initiator for the byte-serial INTERCAL ALU tile. A request
// carries two 32-bit operands and a 4-bit opcode. Changed operand bytes are
// written to the tile one per cycle over ui/uio. The four result bytes are
// then read back through the tile's byte selector and returned as one word.
// Shadow copies of the tile's operand registers let unchanged bytes be
// skipped.
//
// Ports
//   clk, rst            shared clock with the tile; synchronous active-high reset
//   req_valid/ready     request handshake; req_a, req_b operands, req_op opcode
//   rsp_valid/ready     response handshake; rsp_f assembled 32-bit result
//   invalidate          forget shadow contents (tile was reset externally)
//   tile_ui             tile dedicated inputs (registered)
//   tile_uio_out/oe     tile bidirectional pins, host write data and enable (registered)
//   tile_uo             tile result byte, selected by tile_ui[1:0]
//
// Parameter
//   READ_WAIT           extra cycles the selector is held before tile_uo is sampled
module intercal_alu_host #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_f,
    input  logic        invalidate,
    output logic [7:0]  tile_ui,
    output logic [7:0]  tile_uio_out,
    output logic [7:0]  tile_uio_oe,
    input  logic [7:0]  tile_uo
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    // Number of cycles each selector value is driven before its byte is sampled.
    localparam int            HOLD   = READ_WAIT + 1;
    localparam int            CW     = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    state_t            state_q, state_d;
    logic [63:0]       opnd_q, opnd_d;        // {B, A}; byte i = write index i
    logic [3:0]        op_q, op_d;
    logic [7:0]        mask_q, mask_d;        // bytes still to be written
    logic [7:0][7:0]   shadow_q, shadow_d;    // what the tile holds
    logic              shadow_valid_q, shadow_valid_d;
    logic              inval_pend_q, inval_pend_d;
    logic [1:0]        sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_f_q, rsp_f_d;
    logic [7:0]        ui_q, ui_d;
    logic [7:0]        uio_q, uio_d;
    logic [7:0]        oe_q, oe_d;

    logic [63:0]       req_opnd;
    logic              accept;
    logic              sv_eff;
    logic [7:0]        new_mask;
    logic [2:0]        wr_idx;
    logic [7:0]        mask_clr;
    logic              rd_last;

    assign req_opnd  = {req_b, req_a};
    assign req_ready = !rst && (state_q == IDLE) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;

    // An invalidate coincident with the accept must already force a full rewrite.
    assign sv_eff = shadow_valid_q && !invalidate;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            new_mask[i] = !sv_eff || (req_opnd[8*i +: 8] != shadow_q[i]);
        end
    end

    // Lowest set bit of the pending mask: scanning downward leaves the lowest.
    always_comb begin
        wr_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) wr_idx = 3'(i);
        end
    end

    assign mask_clr = mask_q & ~(8'b1 << wr_idx);
    assign rd_last  = (cnt_q == HOLD_C);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (new_mask != 8'd0) ? WRITE : READ;
            WRITE:   if (mask_clr == 8'd0) state_d = READ;
            READ:    if (rd_last && (sel_q == 2'd3)) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        opnd_d         = opnd_q;
        op_d           = op_q;
        mask_d         = mask_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        inval_pend_d   = inval_pend_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_f_d        = rsp_f_q;
        ui_d           = ui_q;
        uio_d          = uio_q;
        oe_d           = oe_q;
        case (state_q)
            IDLE: begin
                if (invalidate) shadow_valid_d = 1'b0;
                if (accept) begin
                    opnd_d = req_opnd;
                    op_d   = req_op;
                    mask_d = new_mask;
                    sel_d  = 2'd0;
                    cnt_d  = '0;
                    // Going straight to READ: park the pins on selector 0
                    // with the new opcode (a non-write pattern).
                    if (new_mask == 8'd0) begin
                        ui_d  = {2'b11, req_op, 2'b00};
                        uio_d = 8'h00;
                        oe_d  = 8'h00;
                    end
                end
            end
            WRITE: begin
                ui_d             = {2'b01, 3'b000, wr_idx};
                uio_d            = opnd_q[8*wr_idx +: 8];
                oe_d             = 8'hFF;
                shadow_d[wr_idx] = opnd_q[8*wr_idx +: 8];
                mask_d           = mask_clr;
                if (mask_clr == 8'd0) shadow_valid_d = 1'b1;
                if (invalidate) inval_pend_d = 1'b1;
            end
            READ: begin
                if (invalidate) inval_pend_d = 1'b1;
                ui_d  = {2'b11, op_q, sel_q};
                uio_d = 8'h00;
                oe_d  = 8'h00;
                if (rd_last) begin
                    rsp_f_d[8*sel_q +: 8] = tile_uo;
                    // The next selector goes out on the sampling edge, so its
                    // first hold cycle is already counted.
                    cnt_d = CW'(1);
                    if (sel_q == 2'd3) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 2'd1;
                        ui_d  = {2'b11, op_q, sel_q + 2'd1};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    // A deferred invalidate takes effect only once the result is gone.
                    if (inval_pend_q || invalidate) shadow_valid_d = 1'b0;
                    inval_pend_d = 1'b0;
                end else if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q         <= '0;
            op_q           <= '0;
            mask_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            inval_pend_q   <= 1'b0;
            sel_q          <= '0;
            cnt_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_f_q        <= '0;
            ui_q           <= 8'hC0;
            uio_q          <= 8'h00;
            oe_q           <= 8'h00;
        end else begin
            opnd_q         <= opnd_d;
            op_q           <= op_d;
            mask_q         <= mask_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            inval_pend_q   <= inval_pend_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_f_q        <= rsp_f_d;
            ui_q           <= ui_d;
            uio_q          <= uio_d;
            oe_q           <= oe_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_f        = rsp_f_q;
    assign tile_ui      = ui_q;
    assign tile_uio_out = uio_q;
    assign tile_uio_oe  = oe_q;

endmodule
